// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown control stage.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT    = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  localparam int NUM_DIGITS = 4;

  // Packed so that index 0 is sec-ones and index 3 is min-tens.
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9};

  function automatic logic [3:0] digit_incr(input logic [3:0] d, input logic [3:0] max);
    return (d == max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that pulses tick on the last count of each TICK_DIV period while run is high.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/timer_control.sv
// Button-driven control FSM for a four-digit MM:SS countdown bank: edit, run/pause, step tick and alarm.
module timer_control
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [15:0] digits_in,
  input  logic        timer_done,
  output logic        run_enable,
  output logic        step,
  output logic [3:0]  digit_set,
  output logic [3:0]  set_value,
  output logic [1:0]  sel_digit,
  output logic [2:0]  state_out,
  output logic        alarm
);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic        btn_start_q, btn_mode_q, btn_inc_q;
  logic        run_enable_q, run_enable_d;
  logic        step_q, step_d;
  logic [3:0]  digit_set_q, digit_set_d;
  logic [3:0]  set_value_q, set_value_d;
  logic        alarm_q, alarm_d;

  logic raw_start, raw_mode, raw_inc;
  logic start_p, mode_p, inc_p;
  logic presc_clear, tick;
  logic [3:0] cur_digit;

  assign raw_start = btn_start & ~btn_start_q;
  assign raw_mode  = btn_mode  & ~btn_mode_q;
  assign raw_inc   = btn_inc   & ~btn_inc_q;

  // Same-cycle presses resolve start > mode > inc; losers are dropped.
  assign start_p = raw_start;
  assign mode_p  = raw_mode & ~raw_start;
  assign inc_p   = raw_inc & ~raw_start & ~raw_mode;

  assign cur_digit = digits_in[{sel_q, 2'b00} +: 4];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .run   (state_q == RUN),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    digit_set_d = '0;
    set_value_d = set_value_q;
    step_d      = 1'b0;
    presc_clear = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_p) begin
          if (!timer_done) begin
            state_d     = RUN;
            presc_clear = 1'b1;
          end
        end else if (mode_p) begin
          state_d = EDIT;
          sel_d   = 2'd0;
        end
      end
      EDIT: begin
        if (start_p) begin
          state_d     = timer_done ? IDLE : RUN;
          presc_clear = 1'b1;
        end else if (mode_p) begin
          if (sel_q == 2'd3) begin
            state_d = IDLE;
            sel_d   = 2'd0;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else if (inc_p) begin
          digit_set_d        = '0;
          digit_set_d[sel_q] = 1'b1;
          set_value_d        = digit_incr(cur_digit, DIGIT_MAX[sel_q]);
        end
      end
      RUN: begin
        // Suppressing the step while done is high keeps the digits from wrapping.
        step_d = tick & ~timer_done;
        if (timer_done)   state_d = EXPIRED;
        else if (start_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_p) begin
          state_d = RUN;
        end else if (mode_p) begin
          state_d     = EDIT;
          sel_d       = 2'd0;
          presc_clear = 1'b1;
        end
      end
      EXPIRED: begin
        if (raw_start | raw_mode | raw_inc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    run_enable_d = (state_d == RUN);
    alarm_d      = (state_d == EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      btn_start_q  <= 1'b0;
      btn_mode_q   <= 1'b0;
      btn_inc_q    <= 1'b0;
      run_enable_q <= 1'b0;
      step_q       <= 1'b0;
      digit_set_q  <= '0;
      set_value_q  <= '0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      btn_start_q  <= btn_start;
      btn_mode_q   <= btn_mode;
      btn_inc_q    <= btn_inc;
      run_enable_q <= run_enable_d;
      step_q       <= step_d;
      digit_set_q  <= digit_set_d;
      set_value_q  <= set_value_d;
      alarm_q      <= alarm_d;
    end
  end

  assign run_enable = run_enable_q;
  assign step       = step_q;
  assign digit_set  = digit_set_q;
  assign set_value  = set_value_q;
  assign sel_digit  = sel_q;
  assign state_out  = state_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_timer_control.sv
// Randomized + directed bench for timer_control; a behavioural model queues expected outputs per cycle.
module tb_timer_control;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, btn_start, btn_mode, btn_inc, timer_done;
  logic [15:0] digits_in;
  logic        run_enable, step, alarm;
  logic [3:0]  digit_set, set_value;
  logic [1:0]  sel_digit;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  timer_control #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .digits_in  (digits_in),
    .timer_done (timer_done),
    .run_enable (run_enable),
    .step       (step),
    .digit_set  (digit_set),
    .set_value  (set_value),
    .sel_digit  (sel_digit),
    .state_out  (state_out),
    .alarm      (alarm)
  );

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: 0=idle 1=edit 2=run 3=pause 4=expired.
  int m_state, m_sel, m_pre, m_sval;
  bit m_pbs, m_pbm, m_pbi;
  logic        cur_td;
  logic [15:0] cur_dig;

  task automatic model_step();
    bit ps, pm, pi, any;
    int nstate, nsel, dset, d, mx;
    bit stp;
    if (reset) begin
      m_state = 0; m_sel = 0; m_pre = 0; m_sval = 0;
      m_pbs = 0; m_pbm = 0; m_pbi = 0;
      exp_q.push_back(16'h0000);
      return;
    end
    ps = btn_start && !m_pbs;
    pm = btn_mode && !m_pbm;
    pi = btn_inc && !m_pbi;
    m_pbs = btn_start; m_pbm = btn_mode; m_pbi = btn_inc;
    any = ps || pm || pi;
    if (ps) begin pm = 0; pi = 0; end
    else if (pm) pi = 0;
    nstate = m_state; nsel = m_sel; dset = 0; stp = 0;
    case (m_state)
      0: begin
        if (ps) begin
          if (!timer_done) begin nstate = 2; m_pre = 0; end
        end else if (pm) begin nstate = 1; nsel = 0; end
      end
      1: begin
        if (ps) begin nstate = timer_done ? 0 : 2; m_pre = 0; end
        else if (pm) begin
          if (m_sel < 3) nsel = m_sel + 1;
          else begin nstate = 0; nsel = 0; end
        end else if (pi) begin
          d = (digits_in >> (4 * m_sel)) & 15;
          mx = (m_sel == 1) ? 5 : 9;
          m_sval = (d == mx) ? 0 : ((d + 1) & 15);
          dset = 1 << m_sel;
        end
      end
      2: begin
        stp = (m_pre == TD - 1) && !timer_done;
        m_pre = (m_pre + 1) % TD;
        if (timer_done) nstate = 4;
        else if (ps) nstate = 3;
      end
      3: begin
        if (ps) nstate = 2;
        else if (pm) begin nstate = 1; nsel = 0; m_pre = 0; end
      end
      default: if (any) nstate = 0;
    endcase
    m_state = nstate; m_sel = nsel;
    exp_q.push_back({3'(nstate), 2'(nsel), (nstate == 2), stp, 4'(dset), 4'(m_sval), (nstate == 4)});
  endtask

  task automatic drive(input bit r, input bit bs, input bit bm, input bit bi);
    reset = r; btn_start = bs; btn_mode = bm; btn_inc = bi;
    timer_done = cur_td; digits_in = cur_dig;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per cycle, sampled 1 time unit after the edge.
  initial begin
    logic [15:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state_out, sel_digit, run_enable, step, digit_set, set_value, alarm};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got st=%0d sel=%0d run=%b step=%b set=%b val=%0d alarm=%b, expected st=%0d sel=%0d run=%b step=%b set=%b val=%0d alarm=%b",
                   $time, got[15:13], got[12:11], got[10], got[9], got[8:5], got[4:1], got[0],
                   e[15:13], e[12:11], e[10], e[9], e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  initial begin
    cur_td = 0; cur_dig = 16'h0000;
    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    idle(2);

    // Edit: select sec-tens, increment at its max and below it.
    drive(0, 0, 1, 0); idle(1);
    drive(0, 0, 1, 0); idle(1);
    cur_dig = 16'h0050; drive(0, 0, 0, 1); idle(2);
    cur_dig = 16'h0040; drive(0, 0, 0, 1); idle(2);
    drive(0, 0, 0, 1); drive(0, 0, 0, 1); idle(1);
    drive(0, 0, 1, 0); idle(1); drive(0, 0, 1, 0); idle(1);
    drive(0, 0, 1, 0); idle(1);

    // Run from 01:30 and watch step cadence, then reset mid-run.
    cur_dig = 16'h0130; drive(0, 1, 0, 0); idle(14);
    drive(1, 0, 0, 0); idle(3);

    // Restart; assert done on the cycle a step is due.
    drive(0, 1, 0, 0); idle(3);
    cur_td = 1; idle(1); cur_td = 0; idle(2);
    drive(0, 0, 1, 0); idle(2);

    // Pause after two run cycles, hold, resume.
    drive(0, 1, 0, 0); idle(1);
    drive(0, 1, 0, 0); idle(10);
    drive(0, 1, 0, 0); idle(6);

    // Start refused while done; start+mode in edit goes to run without moving sel.
    cur_td = 1; idle(2); drive(0, 0, 0, 1); idle(1);
    drive(0, 1, 0, 0); idle(2);
    cur_td = 0; drive(0, 0, 1, 0); idle(1);
    drive(0, 0, 1, 0); idle(1);
    drive(0, 1, 1, 0); idle(6);
    drive(0, 1, 0, 0); idle(2);
    drive(0, 0, 1, 0); idle(1);
    drive(0, 0, 1, 1); idle(2);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      cur_dig = 16'($urandom);
      cur_td  = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 249) == 0,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0);
    end
    idle(2);
    @(posedge clk); #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
